// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - fetch/load-store arbiter for the shared data RAM (RAM_ARB_RR_EN selects round-robin)
module ram_arbiter #(
    parameter int unsigned RAM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_type,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        ram_wr_en,
    output logic [31:0] ram_addr,
    output logic [2:0]  ram_rw_type,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    logic        prio_ls;
    logic [2:0]  ls_type_n;
    logic        ls_err_c;
    logic        if_err_c;
    logic        sel_err;

`ifdef RAM_ARB_RR_EN
    // Contended cycles always produce a grant, so flipping on contention alternates winners.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio_ls <= 1'b1;
        else if (ls_req && if_req)
            prio_ls <= ~prio_ls;
    end
`else
    assign prio_ls = 1'b1;
`endif

    function automatic logic acc_err(input logic [31:0] addr, input logic [2:0] t);
        logic mis;
        case (t[1:0])
            2'b01:   mis = addr[0];
            2'b10:   mis = |addr[1:0];
            default: mis = 1'b0;
        endcase
        return mis || (addr >= 32'(RAM_BYTES));
    endfunction

    always_comb begin
        case (ls_type)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ls_type_n = ls_type;
            default:                                ls_type_n = 3'b010;
        endcase
    end

    assign ls_err_c = acc_err(ls_addr, ls_type_n);
    assign if_err_c = acc_err(if_addr, 3'b010);

    assign ls_gnt  = ls_req && (!if_req || prio_ls);
    assign if_gnt  = if_req && !ls_gnt;
    assign sel_err = ls_gnt ? ls_err_c : if_err_c;

    // Idle cycles present the ls request to the RAM; only a fetch grant steals the port.
    assign ram_addr    = if_gnt ? if_addr : ls_addr;
    assign ram_rw_type = if_gnt ? 3'b010 : ls_type_n;
    assign ram_wdata   = ls_wdata;
    assign ram_wr_en   = rst_n && ls_gnt && ls_we && !ls_err_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rvalid <= 1'b0;
            if_rdata  <= 32'd0;
            if_err    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= 32'd0;
            ls_err    <= 1'b0;
        end else begin
            if_rvalid <= if_gnt;
            ls_rvalid <= ls_gnt;
            if (if_gnt) begin
                if_err   <= sel_err;
                if_rdata <= sel_err ? 32'd0 : ram_rdata;
            end
            if (ls_gnt) begin
                ls_err   <= sel_err;
                ls_rdata <= (sel_err || ls_we) ? 32'd0 : ram_rdata;
            end
        end
    end

endmodule
